// File: rtl/inter_switch_pkg.sv
// rtl/inter_switch_pkg.sv - shared constants, select-width helper and FSM states for the inter switch
package inter_switch_pkg;

    localparam int DEF_DATA_W = 1536;
    localparam int DEF_LAST_W = 24;
    localparam int DEF_N_IN   = 6;
    localparam int DEF_N_OUT  = 9;

    // Width of a 1-based select that also needs a 0 "none" code.
    function automatic int sel_w(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/axis_skid_slice.sv
// rtl/axis_skid_slice.sv - 2-entry full-throughput register slice, ready from registered occupancy
module axis_skid_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign s_ready = (cnt_q != 2'd2);
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = head_q;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Push with simultaneous pop only happens at occupancy 1, so the new beat lands in head.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_q <= s_data;
                else               tail_q <= s_data;
            end
            2'b01:   head_q <= tail_q;
            2'b11:   head_q <= s_data;
            default: head_q <= head_q;
        endcase
    end

endmodule

// File: rtl/inter_switch_nxm.sv
// rtl/inter_switch_nxm.sv - N-in/M-out AXI-Stream crossbar slice with per-packet route lock and drop
module inter_switch_nxm
    import inter_switch_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LAST_W    = DEF_LAST_W,
    parameter int SIDE_W    = 1,
    parameter int N_IN      = DEF_N_IN,
    parameter int N_OUT     = DEF_N_OUT,
    parameter int PKT_LOCK  = 1,
    parameter int SEL_IN_W  = sel_w(N_IN),
    parameter int SEL_OUT_W = sel_w(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_IN_W-1:0]    ctrl_in_sel,
    input  logic [SEL_OUT_W-1:0]   ctrl_out_sel,
    input  logic [SIDE_W-1:0]      s_side,
    input  logic [N_IN*DATA_W-1:0] s_tdata,
    input  logic [N_IN*LAST_W-1:0] s_tlast,
    input  logic [N_IN-1:0]        s_tvalid,
    output logic [N_IN-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic [LAST_W-1:0]      m_tlast,
    output logic [SIDE_W-1:0]      m_side,
    output logic [N_OUT-1:0]       m_tvalid,
    input  logic [N_OUT-1:0]       m_tready,
    output logic                   beat_fire,
    output logic                   drop_pulse,
    output logic                   busy
);

    localparam int PW = SEL_OUT_W + SIDE_W + LAST_W + DATA_W;

    state_e               state_q, state_d;
    logic [SEL_IN_W-1:0]  lock_in_q, lock_in_d;
    logic [SEL_OUT_W-1:0] lock_out_q, lock_out_d;
    logic [SEL_IN_W-1:0]  eff_in;
    logic [SEL_OUT_W-1:0] eff_out;

    logic [DATA_W-1:0]    sel_tdata;
    logic [LAST_W-1:0]    sel_tlast;
    logic                 sel_valid;
    logic                 slice_s_ready;
    logic [PW-1:0]        slice_m_data;
    logic                 slice_m_valid;
    logic                 slice_m_ready;

    logic [SEL_OUT_W-1:0] q_out;
    logic [LAST_W-1:0]    q_tlast;
    logic                 q_ok;
    logic                 out_ready;

    always_comb begin
        if (PKT_LOCK == 0 || state_q == ST_IDLE) begin
            eff_in  = ctrl_in_sel;
            eff_out = ctrl_out_sel;
        end else begin
            eff_in  = lock_in_q;
            eff_out = lock_out_q;
        end
    end

    always_comb begin
        sel_tdata = '0;
        sel_tlast = '0;
        sel_valid = 1'b0;
        s_tready  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (eff_in == SEL_IN_W'(i + 1)) begin
                sel_tdata   = s_tdata[i*DATA_W +: DATA_W];
                sel_tlast   = s_tlast[i*LAST_W +: LAST_W];
                sel_valid   = s_tvalid[i];
                s_tready[i] = slice_s_ready & ~rst;
            end
        end
    end

    assign beat_fire = sel_valid & slice_s_ready & ~rst;

    axis_skid_slice #(.W(PW)) u_slice (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({eff_out, s_side, sel_tlast, sel_tdata}),
        .s_valid (sel_valid),
        .s_ready (slice_s_ready),
        .m_data  (slice_m_data),
        .m_valid (slice_m_valid),
        .m_ready (slice_m_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_in_q  <= '0;
            lock_out_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_in_q  <= lock_in_d;
            lock_out_q <= lock_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_in_d  = lock_in_q;
        lock_out_d = lock_out_q;
        if (PKT_LOCK != 0 && beat_fire) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sel_tlast[0]) begin
                        state_d    = ST_LOCKED;
                        lock_in_d  = eff_in;
                        lock_out_d = eff_out;
                    end
                end
                ST_LOCKED: begin
                    if (sel_tlast[0]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_LOCKED) & ~rst;

    assign q_out   = slice_m_data[PW-1 -: SEL_OUT_W];
    assign m_side  = slice_m_data[DATA_W+LAST_W +: SIDE_W];
    assign q_tlast = slice_m_data[DATA_W +: LAST_W];
    assign m_tdata = slice_m_data[DATA_W-1:0];

    // Beats with no valid destination are popped immediately so they never block the slice.
    always_comb begin
        q_ok      = 1'b0;
        out_ready = 1'b1;
        m_tvalid  = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (q_out == SEL_OUT_W'(j + 1)) begin
                q_ok        = 1'b1;
                out_ready   = m_tready[j];
                m_tvalid[j] = slice_m_valid & ~rst;
            end
        end
    end

    assign slice_m_ready = out_ready;
    assign drop_pulse    = slice_m_valid & ~q_ok & ~rst;
    assign m_tlast       = (|m_tvalid) ? q_tlast : '0;

endmodule

// File: tb/tb_inter_switch_nxm.sv
// tb/tb_inter_switch_nxm.sv - randomized bench against a queue-based packet routing model
module tb_inter_switch_nxm;

    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int SW  = 1;
    localparam int NI  = 6;
    localparam int NO  = 9;
    localparam int SIW = 3;
    localparam int SOW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [SIW-1:0]   ctrl_in_sel;
    logic [SOW-1:0]   ctrl_out_sel;
    logic [SW-1:0]    s_side;
    logic [NI*DW-1:0] s_tdata;
    logic [NI*LW-1:0] s_tlast;
    logic [NI-1:0]    s_tvalid;
    logic [NI-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [LW-1:0]    m_tlast;
    logic [SW-1:0]    m_side;
    logic [NO-1:0]    m_tvalid;
    logic [NO-1:0]    m_tready;
    logic             beat_fire;
    logic             drop_pulse;
    logic             busy;

    inter_switch_nxm #(
        .DATA_W(DW), .LAST_W(LW), .SIDE_W(SW), .N_IN(NI), .N_OUT(NO), .PKT_LOCK(1)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_in_sel(ctrl_in_sel), .ctrl_out_sel(ctrl_out_sel),
        .s_side(s_side), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_side(m_side),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .beat_fire(beat_fire),
        .drop_pulse(drop_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            out;
        logic [DW-1:0] data;
        logic [LW-1:0] last;
        logic [SW-1:0] side;
    } beat_t;

    beat_t q[$];
    bit    in_pkt;
    int    lk_in, lk_out;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    stall    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_s_tready", 64'(s_tready), 0);
        check("rst_m_tvalid", 64'(m_tvalid), 0);
        check("rst_m_tlast", 64'(m_tlast), 0);
        check("rst_beat_fire", 64'(beat_fire), 0);
        check("rst_drop", 64'(drop_pulse), 0);
        check("rst_busy", 64'(busy), 0);
    endtask

    task automatic model_cycle();
        int     e_in, e_out, o;
        bit     in_ok, acc, pop;
        logic [NI-1:0] exp_rdy;
        logic [NO-1:0] exp_mv;
        beat_t  b;
        e_in   = in_pkt ? lk_in  : int'(ctrl_in_sel);
        e_out  = in_pkt ? lk_out : int'(ctrl_out_sel);
        in_ok  = (e_in >= 1 && e_in <= NI);
        exp_rdy = '0;
        if (in_ok && q.size() < 2) exp_rdy[e_in-1] = 1'b1;
        acc = in_ok && q.size() < 2 && s_tvalid[e_in-1];
        check("s_tready", 64'(s_tready), 64'(exp_rdy));
        check("beat_fire", 64'(beat_fire), 64'(acc));
        check("busy", 64'(busy), 64'(in_pkt));

        exp_mv = '0;
        pop    = 1'b0;
        if (q.size() > 0) begin
            o = q[0].out;
            if (o >= 1 && o <= NO) begin
                exp_mv[o-1] = 1'b1;
                pop = m_tready[o-1];
                check("m_tdata", 64'(m_tdata), 64'(q[0].data));
                check("m_side", 64'(m_side), 64'(q[0].side));
                check("m_tlast", 64'(m_tlast), 64'(q[0].last));
            end else begin
                pop = 1'b1;
            end
        end else begin
            check("m_tlast_idle", 64'(m_tlast), 0);
        end
        check("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
        check("drop_pulse", 64'(drop_pulse), 64'(q.size() > 0 && exp_mv == '0));

        if (pop) void'(q.pop_front());
        if (acc) begin
            b.out  = e_out;
            b.data = s_tdata[(e_in-1)*DW +: DW];
            b.last = s_tlast[(e_in-1)*LW +: LW];
            b.side = s_side;
            q.push_back(b);
            if (!in_pkt && !b.last[0]) begin
                in_pkt = 1'b1;
                lk_in  = e_in;
                lk_out = e_out;
            end else if (in_pkt && b.last[0]) begin
                in_pkt = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ctrl_in_sel = '0;
        ctrl_out_sel = '0;
        s_side = '0;
        s_tdata = '0;
        s_tlast = '0;
        s_tvalid = '1;
        m_tready = '1;
        in_pkt = 1'b0;
        lk_in = 0;
        lk_out = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_sel_s_tready", 64'(s_tready), 0);
        check("idle_sel_beat_fire", 64'(beat_fire), 0);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst = (c > 50) && ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ctrl_in_sel = ($urandom_range(0, 9) == 0) ? SIW'($urandom_range(0, 1) * 7)
                                                          : SIW'($urandom_range(1, NI));
                case ($urandom_range(0, 15))
                    0:       ctrl_out_sel = '0;
                    1:       ctrl_out_sel = SOW'($urandom_range(NO + 1, 15));
                    default: ctrl_out_sel = SOW'($urandom_range(1, NO));
                endcase
            end
            s_tvalid = NI'($urandom | $urandom);
            s_side   = SW'($urandom);
            for (int i = 0; i < NI; i++) begin
                s_tdata[i*DW +: DW] = $urandom;
                s_tlast[i*LW +: LW] = LW'({$urandom_range(0, 7), 1'b0} | ($urandom_range(0, 3) == 0));
            end
            if (stall > 0) begin
                stall--;
                m_tready = '0;
            end else if ($urandom_range(0, 59) == 0) begin
                stall = 10;
                m_tready = '0;
            end else begin
                m_tready = NO'($urandom | $urandom);
            end
            @(negedge clk);
            if (rst) begin
                check_reset_outputs();
                q.delete();
                in_pkt = 1'b0;
            end else begin
                model_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inter_switch_nxm.md
Name: inter_switch_nxm

Overview:
- Parametrised N-input, M-output AXI-Stream crossbar slice; successor to the fixed 6-in/9-out inter switch in the data-route fabric between DMA/buffer streams and PE-array/width-converter consumers.
- Selects one input and one output per beat from the ctrl fields. Output select travels in the register-slice payload, so routing stays aligned with data under back-pressure.
- Adds packet lock: the route is frozen from first beat to tlast beat, so ctrl changes mid-packet cannot split a packet.
- Adds drop handling for beats with an invalid output select.

Parameters:
- DATA_W, 1536, tdata width per stream.
- LAST_W, 24, tlast vector width; bit 0 is packet end.
- SIDE_W, 1, sideband width (e.g. weight_switch), carried with data.
- N_IN, 6, input stream count.
- N_OUT, 9, output stream count.
- PKT_LOCK, 1, 1 = lock route per packet; 0 = ctrl sampled every beat.
- SEL_IN_W, $clog2(N_IN+1), input select width.
- SEL_OUT_W, $clog2(N_OUT+1), output select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ctrl_in_sel  in  SEL_IN_W  1..N_IN = input index+1; 0 = idle.
- ctrl_out_sel  in  SEL_OUT_W  1..N_OUT = output index+1; 0 = none.
- s_side  in  SIDE_W  sideband, sampled with the accepted beat.
- s_tdata  in  N_IN*DATA_W  flattened; input i at [i*DATA_W +: DATA_W].
- s_tlast  in  N_IN*LAST_W  flattened likewise.
- s_tvalid  in  N_IN  per-input valid.
- s_tready  out  N_IN  per-input ready.
- m_tdata  out  DATA_W  broadcast to all outputs.
- m_tlast  out  LAST_W  gated to 0 unless a beat is presented.
- m_side  out  SIDE_W  sideband of the presented beat.
- m_tvalid  out  N_OUT  one-hot or zero.
- m_tready  in  N_OUT  per-output ready.
- beat_fire  out  1  input-side accept pulse (s_tvalid & s_tready of the selected input).
- drop_pulse  out  1  one cycle per discarded beat.
- busy  out  1  packet lock held.

Behaviour:
- Reset: slice empty, state IDLE, lock regs 0. All m_tvalid, s_tready, m_tlast, beat_fire, drop_pulse and busy read 0 while rst=1.
- Effective select:
  - eff_in/eff_out = ctrl fields in IDLE or when PKT_LOCK=0.
  - eff_in/eff_out = locked regs in LOCKED.
- eff_in of 0 or >N_IN selects nothing: all s_tready = 0, no beat enters.
- Input mux:
  - s_tready[i] = (eff_in==i+1) & slice_s_ready.
  - Non-selected inputs see ready 0.
  - Payload = {eff_out, s_side, s_tlast[sel], s_tdata[sel]}.
- FSM (PKT_LOCK=1), evaluated on an accepted beat:
  - IDLE -> LOCKED when tlast[0]=0; latches eff_in/eff_out.
  - LOCKED -> IDLE when tlast[0]=1.
  - A single-beat packet (tlast[0]=1 on first beat) stays IDLE.
  - busy = (state==LOCKED).
  - In LOCKED, ctrl changes are ignored.
  - A ctrl change on the tlast cycle takes effect on the next beat.
- Register slice: 2-entry skid, full throughput (1 beat/clk), latency 1 clk from accept to m_tvalid. slice_s_ready depends only on registered occupancy.
- Output side (q_out = head beat's out select):
  - q_out in 1..N_OUT: m_tvalid[q_out-1] = head valid; slice pops on m_tready[q_out-1].
  - q_out = 0 or >N_OUT: no m_tvalid; head pops the same cycle it is valid; drop_pulse=1.
- m_tlast = head tlast when a beat is presented, else 0. m_tdata/m_side show head payload unconditionally.
- Back-pressure: a selected output holding ready=0 stalls the slice; after 2 buffered beats, s_tready of the selected input drops. No beat is lost or duplicated.
- Reset mid-packet: buffered beats discarded, lock cleared, state IDLE next cycle.

Decomposition:
- Package inter_switch_pkg:
  - sel-width function `sel_w(n)`.
  - default DATA_W/LAST_W/N_IN/N_OUT constants.
  - typedef enum state_e {ST_IDLE, ST_LOCKED}.
- Sub-module axis_skid_slice #(W): 2-entry full-throughput register slice with s_valid/s_ready/m_valid/m_ready, sync active-high reset.
- Mux, FSM and output decode stay in the top module.

Test Plan:
- Route: ctrl_in=2, ctrl_out=3, input 1 sends 4 beats (tlast[0] on beat 4), m_tready[2]=1.
  - m_tvalid=9'b000000100 one clk after each accept.
  - Data order preserved; m_tlast=1 on beat 4 only; beat_fire pulses 4 times.
- Packet lock: ctrl_out changes 3->5 after beat 2 of a 4-beat packet.
  - All 4 beats exit output index 2; busy=1 from beat 1 accept through beat 4 accept.
  - The next packet exits output index 4.
- Back-pressure: m_tready[2]=0 for 10 clks during a stream.
  - s_tready[1] falls after 2 beats held; resume yields contiguous data, no loss or duplication.
- Drop: ctrl_out=0, ctrl_in=1, 3 beats.
  - All m_tvalid=0; drop_pulse=1 three times; s_tready stays 1 (full throughput).
- Reset mid-packet: rst=1 for 1 clk after beat 2 with 2 beats buffered.
  - m_tvalid=0 next cycle; busy=0; the following packet routes by new ctrl.
- Idle select: ctrl_in=0 with all s_tvalid=1.
  - s_tready=0 on all inputs; beat_fire=0; m_tvalid=0.
